pulse_delay_scheduler: RTL and testbench
========================================

// Module: pulse_delay_scheduler
// PURPOSE
//  Synthesizable replacement for #delay-based stimulus: drives NCH output
//  channels, each changing to a programmed level a programmed number of clk
//  cycles after a common start. Sits between a host/test controller and
//  the signals it times, e.g. x/y/a/b/c-style strobes. It sequences
//  one run at a time and reports busy/done.
// PARAMETERS
//  NCH  5   number of output channels (1..8)
//  CW   16  delay counter width; max delay 2**CW-1 cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset; asynchronous, active-low
//  cfg_we     in   1      config write strobe (accepted in IDLE only)
//  cfg_ch     in   3      channel index for write; index >= NCH ignored
//  cfg_delay  in   CW     cycles from run start to channel event
//  cfg_level  in   1      level the channel takes at its event
//  cfg_en     in   1      channel enable; disabled channel never fires
//  start      in   1      begin run (level-sampled, IDLE only)
//  abort      in   1      terminate run
//  busy       out  1      1 while state==RUN
//  done       out  1      1-cycle pulse when all enabled channels have fired
//  ch_out     out  NCH    channel outputs (registered)
//  ch_fired   out  NCH    per-channel "event occurred this run" flags
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, cnt=0, busy=0, done=0, ch_out=0,
//    ch_fired=0, all delay/level/en config regs = 0.
//  - Config: cfg_we in IDLE writes delay/level/en of cfg_ch at clk edge;
//    cfg_we in RUN or DONE is dropped.
//  - FSM IDLE -> RUN on start=1 (abort=0); RUN -> DONE when every enabled
//    channel has fired; DONE -> IDLE unconditionally; RUN -> IDLE on abort.
//  - Timing: start sampled at end of cycle 0. Cycle 1: RUN, cnt=0,
//    ch_fired cleared to 0. Cycle k+1: cnt=k. At end of a RUN cycle with
//    cnt==delay[i] and en[i]: ch_out[i]<=level[i], ch_fired[i]<=1. So a
//    delay D channel changes in cycle D+2; delay 0 changes in cycle 2.
//  - Several channels with equal delay change on the same edge.
//  - ch_out holds its value between runs; start does not preload it.
//  - DONE entered in the cycle after last fire (cycle Dmax+2); done=1 for
//    exactly that cycle, busy=0 in it. IDLE from cycle Dmax+3.
//  - No channels enabled: start -> RUN one cycle (cnt=0) -> DONE.
//  - cnt increments in RUN only and saturates at 2**CW-1; never wraps.
//  - abort in RUN: next cycle IDLE, unfired channels keep old ch_out,
//    ch_fired shows partial result, done not pulsed. abort has priority
//    over a same-cycle fire (that fire is suppressed). abort in IDLE or
//    DONE: no effect; start with abort=1 ignored.
//  - start while RUN/DONE ignored (no queuing).
//  - rst_n asserted mid-run: immediate return to reset values.
// CONFIGURATION
//  DLY_SCHED_REPEAT_EN defined: extra input port repeat_mode (1 bit). If
//    repeat_mode=1 when DONE is entered, done pulses as usual and the FSM
//    goes DONE -> RUN (cnt=0, ch_fired cleared) instead of IDLE; abort
//    ends the loop. Config writes are still blocked while looping.
//  Not defined: port absent; DONE always -> IDLE.
// TESTING
//  1 Reset: rst_n=0 mid-clock -> all outputs 0 without a clk edge.
//  2 Delays ch0..4 = 1000,500,0,7,3, levels 0,1,1,1,0, all enabled, ch_out
//    preset to 5'b00000 -> ch2 rises cycle 2, ch4 stays 0 (fires cycle 5),
//    ch3 rises cycle 9, ch1 rises cycle 502; done=1 exactly in cycle 1002.
//  3 ch1 and ch3 both delay 4 -> both change on same edge (cycle 6).
//  4 abort in cycle 300 of test 2 -> IDLE at 301, ch1 not fired,
//    ch_fired=5'b11100 (bits 4..0), no done pulse.
//  5 All cfg_en=0, start -> done in cycle 2, ch_out unchanged; cfg_we
//    during RUN -> config readback unchanged after run.
//  6 (DLY_SCHED_REPEAT_EN) repeat_mode=1, Dmax=3 -> done every 5 cycles
//    until abort; ch_fired clears at each restart.

Source files
------------

// File: rtl/pulse_delay_scheduler.sv
// -----------------------------------------------------------------------------
// pulse_delay_scheduler
//
// Clocked replacement for #delay-based stimulus. Drives NCH output channels.
// Each channel changes to a programmed level a programmed number of clk cycles
// after a common start. One run is sequenced at a time, and busy/done report
// its progress.
//
// Parameters
//   NCH        number of output channels (1..8)
//   CW         delay counter width; largest delay is 2**CW-1 cycles
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   cfg_we       config write strobe, honoured only while idle
//   cfg_ch       channel index for the write; indices >= NCH are ignored
//   cfg_delay    cycles from run start to the channel event
//   cfg_level    level the channel takes at its event
//   cfg_en       channel enable; a disabled channel never fires
//   start        begin a run (level-sampled, idle only, ignored with abort)
//   abort        terminate the current run
//   repeat_mode  (DLY_SCHED_REPEAT_EN only) loop DONE -> RUN until abort
//   busy         1 while a run is in progress
//   done         1-cycle pulse once every enabled channel has fired
//   ch_out       registered channel outputs; held between runs
//   ch_fired     per-channel "event occurred during this run" flags
//
// Optional feature: define DLY_SCHED_REPEAT_EN to add the repeat_mode port.
// -----------------------------------------------------------------------------
module pulse_delay_scheduler #(
    parameter int NCH = 5,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_we,
    input  logic [2:0]     cfg_ch,
    input  logic [CW-1:0]  cfg_delay,
    input  logic           cfg_level,
    input  logic           cfg_en,
    input  logic           start,
    input  logic           abort,
`ifdef DLY_SCHED_REPEAT_EN
    input  logic           repeat_mode,
`endif
    output logic           busy,
    output logic           done,
    output logic [NCH-1:0] ch_out,
    output logic [NCH-1:0] ch_fired
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t         state_r;
    state_t         state_next_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_next_s;
    logic [CW-1:0]  delay_r [NCH];
    logic [NCH-1:0] level_r;
    logic [NCH-1:0] en_r;
    logic [NCH-1:0] ch_out_r;
    logic [NCH-1:0] ch_out_next_s;
    logic [NCH-1:0] ch_fired_r;
    logic [NCH-1:0] ch_fired_next_s;
    logic [NCH-1:0] fire_s;
    logic           all_fired_s;
    logic           cfg_open_s;
    logic           busy_r;
    logic           done_r;
`ifdef DLY_SCHED_REPEAT_EN
    logic           rep_r;
`endif

    assign busy     = busy_r;
    assign done     = done_r;
    assign ch_out   = ch_out_r;
    assign ch_fired = ch_fired_r;

    // Channel events due at the end of this cycle; abort suppresses them.
    always_comb begin
        fire_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if ((state_r == ST_RUN) && !abort && en_r[i] && !ch_fired_r[i]
                && (cnt_r == delay_r[i])) begin
                fire_s[i] = 1'b1;
            end else begin
                fire_s[i] = 1'b0;
            end
        end
        // A disabled channel counts as already fired, so an empty
        // configuration completes after a single RUN cycle.
        all_fired_s = &(ch_fired_r | fire_s | ~en_r);
    end

    // Next-state logic of the run sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (all_fired_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
`ifdef DLY_SCHED_REPEAT_EN
                if (rep_r && !abort) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
`else
                state_next_s = ST_IDLE;
`endif
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the cycle counter, fired flags and channel outputs.
    always_comb begin
        cnt_next_s      = {CW{1'b0}};
        ch_fired_next_s = ch_fired_r;
        ch_out_next_s   = ch_out_r;

        // Counter restarts at 0 on every entry into RUN and saturates.
        if ((state_next_s == ST_RUN) && (state_r == ST_RUN)) begin
            if (cnt_r == CNT_MAX) begin
                cnt_next_s = cnt_r;
            end else begin
                cnt_next_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_next_s = {CW{1'b0}};
        end

        if ((state_next_s == ST_RUN) && (state_r != ST_RUN)) begin
            ch_fired_next_s = {NCH{1'b0}};
        end else if (state_r == ST_RUN) begin
            ch_fired_next_s = ch_fired_r | fire_s;
        end else begin
            ch_fired_next_s = ch_fired_r;
        end

        for (int i = 0; i < NCH; i++) begin
            if (fire_s[i]) begin
                ch_out_next_s[i] = level_r[i];
            end else begin
                ch_out_next_s[i] = ch_out_r[i];
            end
        end
    end

    assign cfg_open_s = (state_r == ST_IDLE) && cfg_we;

    // Per-channel configuration registers, writable only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                delay_r[i] <= {CW{1'b0}};
            end
            level_r <= {NCH{1'b0}};
            en_r    <= {NCH{1'b0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_open_s && (cfg_ch == 3'(i))) begin
                    delay_r[i] <= cfg_delay;
                    level_r[i] <= cfg_level;
                    en_r[i]    <= cfg_en;
                end else begin
                    delay_r[i] <= delay_r[i];
                    level_r[i] <= level_r[i];
                    en_r[i]    <= en_r[i];
                end
            end
        end
    end

    // Sequencer state, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CW{1'b0}};
            ch_out_r   <= {NCH{1'b0}};
            ch_fired_r <= {NCH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            ch_out_r   <= ch_out_next_s;
            ch_fired_r <= ch_fired_next_s;
            busy_r     <= (state_next_s == ST_RUN);
            done_r     <= (state_next_s == ST_DONE);
        end
    end

`ifdef DLY_SCHED_REPEAT_EN
    // repeat_mode is captured as DONE is entered and decides where DONE goes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_r <= 1'b0;
        end else if (state_next_s == ST_DONE) begin
            rep_r <= repeat_mode;
        end else begin
            rep_r <= rep_r;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_delay_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pulse_delay_scheduler
//
// Directed bench for pulse_delay_scheduler (NCH=5, CW=16). Cycle numbers in
// the steps count from the cycle in which start is applied (cycle 0).
// Outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_pulse_delay_scheduler;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [15:0] cfg_delay;
    logic        cfg_level;
    logic        cfg_en;
    logic        start;
    logic        abort;
`ifdef DLY_SCHED_REPEAT_EN
    logic        repeat_mode;
`endif
    logic        busy;
    logic        done;
    logic [4:0]  ch_out;
    logic [4:0]  ch_fired;

    int total;
    int bad;
    int cyc;

    pulse_delay_scheduler #(.NCH(5), .CW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_delay  (cfg_delay),
        .cfg_level  (cfg_level),
        .cfg_en     (cfg_en),
        .start      (start),
        .abort      (abort),
`ifdef DLY_SCHED_REPEAT_EN
        .repeat_mode(repeat_mode),
`endif
        .busy       (busy),
        .done       (done),
        .ch_out     (ch_out),
        .ch_fired   (ch_fired)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic cfg(input logic [2:0] ch, input logic [15:0] dly,
                       input logic lvl, input logic en);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_delay = dly;
        cfg_level = lvl;
        cfg_en    = en;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic start_run();
        cyc   = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic cfg_test2();
        cfg(3'd0, 16'd1000, 1'b0, 1'b1);
        cfg(3'd1, 16'd500,  1'b1, 1'b1);
        cfg(3'd2, 16'd0,    1'b1, 1'b1);
        cfg(3'd3, 16'd7,    1'b1, 1'b1);
        cfg(3'd4, 16'd3,    1'b0, 1'b1);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = 3'd0; cfg_delay = 16'd0;
        cfg_level = 1'b0; cfg_en = 1'b0; start = 1'b0; abort = 1'b0;
`ifdef DLY_SCHED_REPEAT_EN
        repeat_mode = 1'b0;
`endif
        // Reset values are visible before any clock edge.
        #2;
        check("rst_busy",   busy,     32'd0);
        check("rst_done",   done,     32'd0);
        check("rst_chout",  ch_out,   32'd0);
        check("rst_fired",  ch_fired, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Staggered delays 1000/500/0/7/3, levels 0/1/1/1/0.
        cfg_test2();
        start_run();
        check("t2_c1_busy",  busy,     32'd1);
        check("t2_c1_fired", ch_fired, 32'd0);
        check("t2_c1_out",   ch_out,   32'd0);
        step();
        check("t2_c2_out",   ch_out,   32'h04);
        check("t2_c2_fired", ch_fired, 32'h04);
        run_to(5);
        check("t2_c5_out",   ch_out,   32'h04);
        check("t2_c5_fired", ch_fired, 32'h14);
        run_to(8);
        check("t2_c8_out",   ch_out,   32'h04);
        step();
        check("t2_c9_out",   ch_out,   32'h0C);
        run_to(501);
        check("t2_c501_out", ch_out,   32'h0C);
        step();
        check("t2_c502_out", ch_out,   32'h0E);
        run_to(1001);
        check("t2_c1001_done", done,   32'd0);
        check("t2_c1001_busy", busy,   32'd1);
        step();
        check("t2_c1002_done", done,     32'd1);
        check("t2_c1002_busy", busy,     32'd0);
        check("t2_c1002_out",  ch_out,   32'h0E);
        check("t2_c1002_fired",ch_fired, 32'h1F);
        step();
        check("t2_c1003_done", done,   32'd0);
        check("t2_c1003_busy", busy,   32'd0);

        // Reset asserted mid-run clears everything without a clock edge.
        start_run();
        run_to(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy",  busy,     32'd0);
        check("midrst_out",   ch_out,   32'd0);
        check("midrst_fired", ch_fired, 32'd0);
        rst_n = 1'b1;
        step();
        check("midrst_idle",  busy,     32'd0);

        // Abort in cycle 300 of the staggered run.
        cfg_test2();
        start_run();
        run_to(300);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_c301_busy",  busy,     32'd0);
        check("ab_c301_done",  done,     32'd0);
        check("ab_c301_fired", ch_fired, 32'h1C);
        check("ab_c301_out",   ch_out,   32'h0C);
        step();
        check("ab_c302_done",  done,     32'd0);
        run_to(320);
        check("ab_c320_busy",  busy,     32'd0);
        check("ab_c320_fired", ch_fired, 32'h1C);

        // Abort in the cycle ch3 (delay 7) would fire suppresses that fire.
        start_run();
        run_to(8);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abfire_fired", ch_fired, 32'h14);
        check("abfire_busy",  busy,     32'd0);

        // start together with abort is ignored.
        cyc = 0;
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 32'd0);

        // Equal delays: ch1 and ch3 both at 4 change on the same edge.
        pulse_reset();
        cfg(3'd1, 16'd4, 1'b1, 1'b1);
        cfg(3'd3, 16'd4, 1'b1, 1'b1);
        cyc = 0;
        start = 1'b1;
        step();
        run_to(5);
        check("eq_c5_out",  ch_out, 32'h00);
        check("eq_c5_busy", busy,   32'd1);
        step();
        check("eq_c6_out",  ch_out, 32'h0A);
        check("eq_c6_done", done,   32'd1);
        step();
        start = 1'b0;
        check("eq_c7_busy", busy,   32'd0);
        step();
        check("eq_c8_busy", busy,   32'd0);

        // No channel enabled: done in cycle 2, outputs held, RUN writes dropped.
        cfg(3'd1, 16'd4, 1'b1, 1'b0);
        cfg(3'd3, 16'd4, 1'b1, 1'b0);
        start_run();
        check("none_c1_busy", busy, 32'd1);
        cfg(3'd0, 16'd0, 1'b1, 1'b1);
        check("none_c2_done", done,   32'd1);
        check("none_c2_busy", busy,   32'd0);
        check("none_c2_out",  ch_out, 32'h0A);
        step();
        check("none_c3_done", done,   32'd0);
        start_run();
        step();
        check("none2_c2_done",  done,     32'd1);
        check("none2_c2_out",   ch_out,   32'h0A);
        check("none2_c2_fired", ch_fired, 32'h00);
        step();

`ifdef DLY_SCHED_REPEAT_EN
        // Repeat mode, Dmax=3: done every 5 cycles until abort.
        pulse_reset();
        cfg(3'd0, 16'd3, 1'b1, 1'b1);
        repeat_mode = 1'b1;
        start_run();
        run_to(5);
        check("rep_c5_done",   done,     32'd1);
        check("rep_c5_fired",  ch_fired, 32'h01);
        step();
        check("rep_c6_busy",   busy,     32'd1);
        check("rep_c6_fired",  ch_fired, 32'h00);
        check("rep_c6_done",   done,     32'd0);
        run_to(10);
        check("rep_c10_done",  done,     32'd1);
        run_to(12);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("rep_c13_busy",  busy,     32'd0);
        run_to(15);
        check("rep_c15_done",  done,     32'd0);
        repeat_mode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
